// File: rtl/button_event_arbiter_pkg.sv
// Shared event codes and sizing helpers for the button event arbiter.
package button_event_arbiter_pkg;

    localparam int EVT_TYPE_W = 2;

    typedef enum logic [EVT_TYPE_W-1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2,
        EVT_HOLD    = 2'd3
    } evt_type_e;

    // Width of a button index; a single button still needs one bit.
    function automatic int btn_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Valid/ready event port shared by all buttons, plus the drop pulse.
interface button_event_arbiter_if #(
    parameter int N_BTN = 4
);
    import button_event_arbiter_pkg::*;

    localparam int BTN_W = btn_idx_w(N_BTN);

    logic                  evt_valid;
    logic                  evt_ready;
    logic [BTN_W-1:0]      evt_btn;
    logic [EVT_TYPE_W-1:0] evt_type;
    logic                  evt_drop;

    modport master (
        output evt_valid,
        output evt_btn,
        output evt_type,
        output evt_drop,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_btn,
        input  evt_type,
        input  evt_drop,
        output evt_ready
    );

endinterface

// File: rtl/button_event_arbiter_chan.sv
// One button channel: edge detect, long-press/repeat timer and the three
// pending event flags that the arbiter clears when it serves them.
module btn_evt_chan #(
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_in,
    input  logic clr_press,
    input  logic clr_hold,
    input  logic clr_release,
    output logic pend_press,
    output logic pend_hold,
    output logic pend_release,
    output logic drop
);

    localparam logic [CNT_W-1:0] LONG_LOAD   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);

    logic             btn_d_q;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             pend_press_q, pend_press_d;
    logic             pend_hold_q, pend_hold_d;
    logic             pend_release_q, pend_release_d;
    logic             rise, fall, hold_tick, block;

    // A new press must not overtake an older RELEASE still waiting; a
    // RELEASE being served on this very edge no longer blocks it.
    always_comb begin
        rise      = btn_in & ~btn_d_q;
        fall      = ~btn_in & btn_d_q;
        hold_tick = btn_in & btn_d_q & (timer_q == '0);
        block     = pend_press_q | (pend_release_q & ~clr_release);
        drop      = rise & block;

        timer_d = timer_q;
        if (!btn_in) begin
            timer_d = '0;
        end else if (rise) begin
            timer_d = LONG_LOAD;
        end else if (hold_tick) begin
            timer_d = REPEAT_LOAD;
        end else begin
            timer_d = timer_q - 1'b1;
        end

        pend_press_d   = (pend_press_q & ~clr_press) | (rise & ~block);
        pend_hold_d    = (pend_hold_q | hold_tick) & ~clr_hold & btn_in;
        pend_release_d = (pend_release_q & ~clr_release) | fall;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_d_q        <= 1'b0;
            timer_q        <= '0;
            pend_press_q   <= 1'b0;
            pend_hold_q    <= 1'b0;
            pend_release_q <= 1'b0;
        end else begin
            btn_d_q        <= btn_in;
            timer_q        <= timer_d;
            pend_press_q   <= pend_press_d;
            pend_hold_q    <= pend_hold_d;
            pend_release_q <= pend_release_d;
        end
    end

    assign pend_press   = pend_press_q;
    assign pend_hold    = pend_hold_q;
    assign pend_release = pend_release_q;

    no_double_release: assert property (@(posedge clk) disable iff (!resetn)
        !(fall && pend_release_q && !clr_release));

endmodule

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into PRESS/RELEASE/HOLD events and shares
// one registered valid/ready port among the buttons round-robin.
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200,
    parameter int CNT_W         = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [N_BTN-1:0]              btn_in,
    button_event_arbiter_if.master        evt
);

    localparam int BTN_W = btn_idx_w(N_BTN);

    logic [N_BTN-1:0] pend_press, pend_hold, pend_release, drop_vec;
    logic [N_BTN-1:0] clr_press, clr_hold, clr_release;

    logic                  evt_valid_q, evt_valid_d;
    logic [BTN_W-1:0]      evt_btn_q, evt_btn_d;
    logic [EVT_TYPE_W-1:0] evt_type_q, evt_type_d;
    logic                  evt_drop_q, evt_drop_d;
    logic [BTN_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic             found, load_en;
    logic [BTN_W-1:0] win;
    int               idx;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_evt_chan #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clk          (clk),
            .resetn       (resetn),
            .btn_in       (btn_in[i]),
            .clr_press    (clr_press[i]),
            .clr_hold     (clr_hold[i]),
            .clr_release  (clr_release[i]),
            .pend_press   (pend_press[i]),
            .pend_hold    (pend_hold[i]),
            .pend_release (pend_release[i]),
            .drop         (drop_vec[i])
        );
    end

    // The output register reloads whenever it is empty or being accepted,
    // so a held-high ready gives one event per clock with no bubble.
    always_comb begin
        clr_press   = '0;
        clr_hold    = '0;
        clr_release = '0;
        evt_valid_d = evt_valid_q;
        evt_btn_d   = evt_btn_q;
        evt_type_d  = evt_type_q;
        rr_ptr_d    = rr_ptr_q;
        evt_drop_d  = |drop_vec;
        found       = 1'b0;
        win         = '0;
        idx         = 0;
        load_en     = ~evt_valid_q | evt.evt_ready;

        for (int k = 0; k < N_BTN; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            if (!found && (pend_press[idx] || pend_hold[idx] || pend_release[idx])) begin
                found = 1'b1;
                win   = BTN_W'(idx);
            end
        end

        if (load_en) begin
            if (found) begin
                evt_valid_d = 1'b1;
                evt_btn_d   = win;
                if (pend_press[win]) begin
                    evt_type_d     = EVT_PRESS;
                    clr_press[win] = 1'b1;
                end else if (pend_hold[win]) begin
                    evt_type_d    = EVT_HOLD;
                    clr_hold[win] = 1'b1;
                end else begin
                    evt_type_d       = EVT_RELEASE;
                    clr_release[win] = 1'b1;
                end
                rr_ptr_d = (win == BTN_W'(N_BTN - 1)) ? '0 : win + 1'b1;
            end else begin
                evt_valid_d = 1'b0;
                evt_btn_d   = '0;
                evt_type_d  = EVT_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            evt_valid_q <= 1'b0;
            evt_btn_q   <= '0;
            evt_type_q  <= EVT_NONE;
            evt_drop_q  <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_btn_q   <= evt_btn_d;
            evt_type_q  <= evt_type_d;
            evt_drop_q  <= evt_drop_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_btn   = evt_btn_q;
    assign evt.evt_type  = evt_type_q;
    assign evt.evt_drop  = evt_drop_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with short hold timings
// (LONG_CYCLES=8, REPEAT_CYCLES=4) so long-press and repeat fit in a few clocks.
module tb_button_event_arbiter;
    import button_event_arbiter_pkg::*;

    logic       clk;
    logic       resetn;
    logic [3:0] btn_in;
    int         checkCount;
    int         passCount;

    button_event_arbiter_if #(.N_BTN(4)) evt_if ();

    button_event_arbiter #(
        .N_BTN         (4),
        .LONG_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .CNT_W         (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .btn_in (btn_in),
        .evt    (evt_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here so the summary counts stay honest.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive inputs, then step one rising edge and settle just after it.
    task automatic applyStimulus(input logic [3:0] btn, input logic ready);
        btn_in           = btn;
        evt_if.evt_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic expectEvt(input string tag, input int valid, input int btn,
                             input int typ, input int drop);
        checkOutput({tag, " valid"}, int'(evt_if.evt_valid), valid);
        checkOutput({tag, " drop"}, int'(evt_if.evt_drop), drop);
        if (valid != 0) begin
            checkOutput({tag, " btn"}, int'(evt_if.evt_btn), btn);
            checkOutput({tag, " type"}, int'(evt_if.evt_type), typ);
        end
    endtask

    task automatic resetDut();
        resetn           = 1'b0;
        btn_in           = 4'b0000;
        evt_if.evt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        checkCount       = 0;
        passCount        = 0;
        resetn           = 1'b0;
        btn_in           = 4'b0000;
        evt_if.evt_ready = 1'b1;
        #12;
        checkOutput("reset valid", int'(evt_if.evt_valid), 0);
        checkOutput("reset btn", int'(evt_if.evt_btn), 0);
        checkOutput("reset type", int'(evt_if.evt_type), 0);
        checkOutput("reset drop", int'(evt_if.evt_drop), 0);

        // Single short press: PRESS one cycle after sampling, then RELEASE.
        resetDut();
        for (int c = 0; c < 6; c++) begin
            applyStimulus((c < 3) ? 4'b0001 : 4'b0000, 1'b1);
            if (c == 1)
                expectEvt($sformatf("t1 c%0d", c), 1, 0, int'(EVT_PRESS), 0);
            else if (c == 4)
                expectEvt($sformatf("t1 c%0d", c), 1, 0, int'(EVT_RELEASE), 0);
            else
                expectEvt($sformatf("t1 c%0d", c), 0, 0, 0, 0);
        end

        // Long press: HOLD at +8, +12, +16 after PRESS, then RELEASE.
        resetDut();
        for (int c = 0; c < 25; c++) begin
            applyStimulus((c < 20) ? 4'b0001 : 4'b0000, 1'b1);
            if (c == 1)
                expectEvt($sformatf("t2 c%0d", c), 1, 0, int'(EVT_PRESS), 0);
            else if (c == 9 || c == 13 || c == 17)
                expectEvt($sformatf("t2 c%0d", c), 1, 0, int'(EVT_HOLD), 0);
            else if (c == 21)
                expectEvt($sformatf("t2 c%0d", c), 1, 0, int'(EVT_RELEASE), 0);
            else
                expectEvt($sformatf("t2 c%0d", c), 0, 0, 0, 0);
        end

        // All four at once: presses 0..3 back to back, releases 0..3 after wrap.
        resetDut();
        for (int c = 0; c < 11; c++) begin
            applyStimulus((c < 5) ? 4'b1111 : 4'b0000, 1'b1);
            if (c >= 1 && c <= 4)
                expectEvt($sformatf("t3 c%0d", c), 1, c - 1, int'(EVT_PRESS), 0);
            else if (c >= 6 && c <= 9)
                expectEvt($sformatf("t3 c%0d", c), 1, c - 6, int'(EVT_RELEASE), 0);
            else
                expectEvt($sformatf("t3 c%0d", c), 0, 0, 0, 0);
        end

        // Back-pressure: first PRESS frozen for 10 clocks, nothing lost afterwards.
        resetDut();
        for (int c = 0; c < 19; c++) begin
            applyStimulus((c < 5) ? 4'b1111 : 4'b0000, (c >= 11) ? 1'b1 : 1'b0);
            if (c >= 1 && c <= 10)
                expectEvt($sformatf("t4 c%0d", c), 1, 0, int'(EVT_PRESS), 0);
            else if (c >= 11 && c <= 13)
                expectEvt($sformatf("t4 c%0d", c), 1, c - 10, int'(EVT_PRESS), 0);
            else if (c >= 14 && c <= 17)
                expectEvt($sformatf("t4 c%0d", c), 1, c - 14, int'(EVT_RELEASE), 0);
            else
                expectEvt($sformatf("t4 c%0d", c), 0, 0, 0, 0);
        end

        // Re-press while RELEASE is still waiting: dropped with a one-clock pulse.
        resetDut();
        for (int c = 0; c < 7; c++) begin
            applyStimulus((c == 1) ? 4'b0000 : 4'b0010, (c >= 5) ? 1'b1 : 1'b0);
            if (c >= 1 && c <= 4)
                expectEvt($sformatf("t5 c%0d", c), 1, 1, int'(EVT_PRESS), (c == 2) ? 1 : 0);
            else if (c == 5)
                expectEvt($sformatf("t5 c%0d", c), 1, 1, int'(EVT_RELEASE), 0);
            else
                expectEvt($sformatf("t5 c%0d", c), 0, 0, 0, 0);
        end

        // Reset during a stalled long-press: outputs clear at once, and the
        // still-held button yields exactly one PRESS after reset is released.
        resetDut();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(4'b0101, 1'b0);
            if (c >= 1)
                expectEvt($sformatf("t6 c%0d", c), 1, 0, int'(EVT_PRESS), 0);
            else
                expectEvt($sformatf("t6 c%0d", c), 0, 0, 0, 0);
        end
        resetn = 1'b0;
        #1;
        checkOutput("t6 async valid", int'(evt_if.evt_valid), 0);
        checkOutput("t6 async btn", int'(evt_if.evt_btn), 0);
        checkOutput("t6 async type", int'(evt_if.evt_type), 0);
        checkOutput("t6 async drop", int'(evt_if.evt_drop), 0);
        btn_in           = 4'b0001;
        evt_if.evt_ready = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(4'b0001, 1'b1);
            if (c == 1)
                expectEvt($sformatf("t6 r%0d", c), 1, 0, int'(EVT_PRESS), 0);
            else
                expectEvt($sformatf("t6 r%0d", c), 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
